// File: rtl/spi_reg_bank.sv
// Register bank behind an SPI slave: a command byte selects one of 16 words, then a 32-bit data word is read or written.
// Latency: rdata is loaded 1 clk after cmd_valid; a write lands (with wr_stb) 1 clk after data_valid; status is loaded on the frame_end edge.
// Backpressure: none; every input is a one-clk pulse and is acted on, or flagged as a protocol error, in the cycle it arrives.
module spi_reg_bank #(
    parameter logic [31:0] ID_VALUE = 32'h5350_4931,
    parameter int          NREG     = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        frame_end,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd,
    input  logic        data_valid,
    input  logic [31:0] wdata,
    output logic [7:0]  status,
    output logic [31:0] rdata,
    output logic        wr_stb,
    output logic [3:0]  wr_addr,
    output logic [31:0] q0,
    output logic [31:0] q1
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] regs [0:NREG-1];
    logic        wr_flag_q;
    logic [3:0]  addr_q;
    logic [3:0]  frame_cnt_q, frame_cnt_d;
    logic        abort_err_q, abort_err_d;
    logic        proto_err_q, proto_err_d;
    logic        last_wr_q, last_wr_d;
    logic        cmd_take, commit, abort_set, proto_set;
    logic        wr_reg, wr_id;
    logic [31:0] rd_word;

    // Frame sequencing: frame_start always restarts the command phase, a premature end aborts.
    always_comb begin
        state_d   = state_q;
        cmd_take  = 1'b0;
        commit    = 1'b0;
        abort_set = 1'b0;
        proto_set = 1'b0;
        if (frame_start) begin
            state_d = CMD;
            if (state_q == DATA) abort_set = 1'b1;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                CMD: begin
                    if (frame_end) begin
                        state_d = IDLE;
                    end else if (cmd_valid) begin
                        state_d  = DATA;
                        cmd_take = 1'b1;
                    end
                end
                DATA: begin
                    if (data_valid) begin
                        commit  = 1'b1;
                        state_d = frame_end ? IDLE : DONE;
                    end else if (frame_end) begin
                        state_d   = IDLE;
                        abort_set = 1'b1;
                    end
                end
                DONE: if (frame_end) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        if (cmd_valid && state_q != CMD) proto_set = 1'b1;
        if (data_valid && state_q != DATA) proto_set = 1'b1;
    end

    // Next values of the sticky status fields; an error raised in the same cycle beats an ID-write clear.
    always_comb begin
        wr_reg      = commit && wr_flag_q && (int'(addr_q) < NREG);
        wr_id       = commit && wr_flag_q && (addr_q == 4'hF);
        abort_err_d = abort_set ? 1'b1 : (wr_id ? 1'b0 : abort_err_q);
        proto_err_d = proto_set ? 1'b1 : (wr_id ? 1'b0 : proto_err_q);
        frame_cnt_d = commit ? frame_cnt_q + 4'd1 : frame_cnt_q;
        last_wr_d   = commit ? wr_flag_q : last_wr_q;
    end

    // Read mux: address 15 is the fixed ID word, unused addresses read as zero.
    always_comb begin
        rd_word = '0;
        if (cmd[3:0] == 4'hF) rd_word = ID_VALUE;
        else if (int'(cmd[3:0]) < NREG) rd_word = regs[cmd[3:0]];
    end

    // State register plus the sticky status fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            abort_err_q <= 1'b0;
            proto_err_q <= 1'b0;
            last_wr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            abort_err_q <= abort_err_d;
            proto_err_q <= proto_err_d;
            last_wr_q   <= last_wr_d;
        end
    end

    // Command latch and read-data load, one clk after the command byte arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_flag_q <= 1'b0;
            addr_q    <= '0;
            rdata     <= '0;
        end else if (cmd_take) begin
            wr_flag_q <= cmd[7];
            addr_q    <= cmd[3:0];
            rdata     <= cmd[7] ? 32'd0 : rd_word;
        end
    end

    // Register file update and write strobe on commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
        end else begin
            wr_stb <= commit && wr_flag_q;
            if (commit && wr_flag_q) wr_addr <= addr_q;
            if (wr_reg) regs[addr_q] <= wdata;
        end
    end

    // Status snapshot taken only at frame end so it is stable while the next frame shifts it out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status <= 8'h80;
        end else if (frame_end) begin
            status <= {1'b1, abort_err_d, proto_err_d, last_wr_d, frame_cnt_d};
        end
    end

    assign q0 = regs[0];
    assign q1 = regs[1];

endmodule

// File: tb/tb_spi_reg_bank.sv
module tb_spi_reg_bank;

    localparam logic [31:0] ID = 32'h5350_4931;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        frame_end = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic        data_valid = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [7:0]  status;
    logic [31:0] rdata;
    logic        wr_stb;
    logic [3:0]  wr_addr;
    logic [31:0] q0, q1;

    spi_reg_bank dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
        .cmd_valid(cmd_valid), .cmd(cmd), .data_valid(data_valid), .wdata(wdata),
        .status(status), .rdata(rdata), .wr_stb(wr_stb), .wr_addr(wr_addr),
        .q0(q0), .q1(q1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] q0;
        logic [31:0] q1;
    } wr_exp_t;

    wr_exp_t     wr_q[$];
    logic [31:0] rd_q[$];
    logic [7:0]  st_q[$];

    // Reference model: what the bank should hold according to the transfer rules.
    logic [31:0] m_regs [16];
    logic [3:0]  m_cnt;
    bit          m_abort, m_proto, m_lww;
    logic [31:0] m_rdata;
    bit          m_in_cmd, m_in_data, cur_wr;
    logic [3:0]  cur_addr;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        m_cnt = 4'd0; m_abort = 0; m_proto = 0; m_lww = 0; m_rdata = 32'h0;
        m_in_cmd = 0; m_in_data = 0; cur_wr = 0; cur_addr = 4'd0;
    endfunction

    function automatic logic [7:0] m_status();
        return {1'b1, m_abort, m_proto, m_lww, m_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against expectations queued by the stimulus.
    bit pend_cmd = 0, pend_fe = 0;
    always @(negedge clk) begin
        if (rst) begin
            pend_cmd = 0;
            pend_fe  = 0;
        end else begin
            if (pend_cmd) begin
                if (rd_q.size() == 0) check("rdata_unexpected", 32'h1, 32'h0);
                else check("rdata", rdata, rd_q.pop_front());
            end
            if (wr_stb) begin
                if (wr_q.size() == 0) begin
                    check("wr_stb_unexpected", {28'h0, wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    wr_exp_t e;
                    e = wr_q.pop_front();
                    check("wr_addr", {28'h0, wr_addr}, {28'h0, e.addr});
                    check("q0", q0, e.q0);
                    check("q1", q1, e.q1);
                end
            end
            if (pend_fe) begin
                if (st_q.size() == 0) check("status_unexpected", 32'h1, 32'h0);
                else check("status", {24'h0, status}, {24'h0, st_q.pop_front()});
            end
            pend_cmd = cmd_valid;
            pend_fe  = frame_end;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        if (m_in_data) m_abort = 1;
        m_in_cmd = 1; m_in_data = 0;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        cmd_valid = 1'b1;
        cmd = c;
        if (m_in_cmd) begin
            cur_wr   = c[7];
            cur_addr = c[3:0];
            if (c[7]) m_rdata = 32'h0;
            else if (c[3:0] == 4'hF) m_rdata = ID;
            else m_rdata = m_regs[c[3:0]];
            m_in_cmd = 0; m_in_data = 1;
        end else begin
            m_proto = 1;
        end
        rd_q.push_back(m_rdata);
        tick();
        cmd_valid = 1'b0;
        cmd = 8'($urandom);
    endtask

    task automatic send_data(input logic [31:0] d, input bit with_end);
        data_valid = 1'b1;
        wdata = d;
        frame_end = with_end;
        if (m_in_data) begin
            if (cur_wr) begin
                wr_exp_t e;
                if (cur_addr == 4'hF) begin
                    m_abort = 0; m_proto = 0;
                end else begin
                    m_regs[cur_addr] = d;
                end
                e.addr = cur_addr; e.q0 = m_regs[0]; e.q1 = m_regs[1];
                wr_q.push_back(e);
            end
            m_cnt = m_cnt + 4'd1;
            m_lww = cur_wr;
            m_in_data = 0;
        end else begin
            m_proto = 1;
        end
        if (with_end) begin
            m_in_cmd = 0;
            st_q.push_back(m_status());
        end
        tick();
        data_valid = 1'b0;
        frame_end = 1'b0;
        wdata = $urandom;
    endtask

    task automatic end_frame();
        frame_end = 1'b1;
        if (m_in_data) m_abort = 1;
        m_in_cmd = 0; m_in_data = 0;
        st_q.push_back(m_status());
        tick();
        frame_end = 1'b0;
    endtask

    task automatic do_frame(input logic [7:0] c, input logic [31:0] d);
        pulse_start(); gap();
        send_cmd(c); gap();
        send_data(d, 1'b0); gap();
        end_frame(); tick();
    endtask

    function automatic logic [7:0] rcmd(input bit w, input logic [3:0] a);
        logic [2:0] junk;
        junk = 3'($urandom);
        return {w, junk, a};
    endfunction

    task automatic do_reset();
        tick(); tick();
        rst = 1'b1;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        model_reset();
        tick(); tick();
        check("rst_status", {24'h0, status}, 32'h80);
        check("rst_rdata", rdata, 32'h0);
        check("rst_wr_stb", {31'h0, wr_stb}, 32'h0);
        check("rst_q0", q0, 32'h0);
        check("rst_q1", q1, 32'h0);
        rst = 1'b0;
        tick();

        // Write then read back register 0.
        do_frame(8'hB0, 32'h24AF55AA);
        do_frame(8'h00, $urandom);
        check("q0_direct", q0, 32'h24AF55AA);

        // Fresh write to register 1, status then reads 0x91.
        do_reset();
        do_frame(8'h81, 32'h01234567);
        check("q1_direct", q1, 32'h01234567);
        check("status_after_w1", {24'h0, status}, 32'h91);

        // ID word: readable, write leaves it and clears errors.
        do_frame(8'h0F, $urandom);
        do_frame(8'h8F, $urandom);
        do_frame(8'h0F, $urandom);

        // End during DATA aborts; an ID write clears it.
        pulse_start(); send_cmd(8'h83); gap(); end_frame(); tick();
        check("abort_bit6", {31'h0, status[6]}, 32'h1);
        do_frame(8'h8F, $urandom);
        check("abort_cleared", {31'h0, status[6]}, 32'h0);

        // Restart during DATA aborts the first frame, then the second completes.
        pulse_start(); send_cmd(rcmd(1, 4'd4)); gap();
        pulse_start(); send_cmd(rcmd(1, 4'd5)); send_data($urandom, 1'b0); end_frame(); tick();

        // Data and end in the same cycle still commit.
        pulse_start(); send_cmd(rcmd(1, 4'd1)); send_data($urandom, 1'b1); tick();

        // Counter wrap after 17 frames, then a stray data_valid.
        do_reset();
        for (int i = 0; i < 17; i++) do_frame(rcmd(1'($urandom), 4'($urandom)), $urandom);
        check("cnt_wrap", {28'h0, status[3:0]}, 32'h1);
        send_data($urandom, 1'b0); tick();
        pulse_start(); end_frame(); tick();
        check("proto_bit5", {31'h0, status[5]}, 32'h1);

        // Stray cmd_valid in IDLE leaves rdata alone.
        send_cmd(rcmd(0, 4'd1)); tick();
        pulse_start(); end_frame(); tick();

        // Random mix of frame shapes.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 6))
                0: do_frame(rcmd(1, 4'($urandom)), $urandom);
                1: do_frame(rcmd(0, 4'($urandom)), $urandom);
                2: begin pulse_start(); send_cmd(rcmd(1'($urandom), 4'($urandom))); gap(); end_frame(); tick(); end
                3: begin pulse_start(); gap(); end_frame(); tick(); end
                4: begin pulse_start(); send_cmd(rcmd(1'($urandom), 4'($urandom))); gap(); send_data($urandom, 1'b1); tick(); end
                5: begin
                    pulse_start(); send_cmd(rcmd(1'($urandom), 4'($urandom))); gap();
                    pulse_start(); send_cmd(rcmd(1'($urandom), 4'($urandom)));
                    send_data($urandom, 1'b0); end_frame(); tick();
                end
                default: begin send_data($urandom, 1'b0); tick(); end
            endcase
        end

        // Reset one clk before data_valid discards the write to register 2.
        do_reset();
        pulse_start(); send_cmd(8'h82); tick();
        rst = 1'b1;
        model_reset();
        tick();
        data_valid = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        data_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("rst_abort_status", {24'h0, status}, 32'h80);
        do_frame(8'h02, $urandom);

        tick(); tick();
        check("rd_q_left", rd_q.size(), 32'h0);
        check("wr_q_left", wr_q.size(), 32'h0);
        check("st_q_left", st_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
